// File: rtl/clock_div_pkg.sv
// Purpose: shared constants and helpers for the game clock dividers.
// Latency: n/a (compile-time constants only).
// Backpressure: n/a.
package clock_div_pkg;

   // Board system clock frequency in Hz.
   localparam int SYS_CLK_HZ = 100_000_000;

   // Target output frequencies of the two divided clocks.
   localparam int FAST_CLK_HZ  = 500;
   localparam int BLINK_CLK_HZ = 2;

   // Number of system clock edges per half-period of a square wave at target_hz.
   function automatic int half_cycles(input int target_hz);
      return SYS_CLK_HZ / (2 * target_hz);
   endfunction

   // Default half-period lengths: 100000 (500 Hz) and 25000000 (2 Hz).
   localparam int DEF_FAST_HALF_CYCLES  = half_cycles(FAST_CLK_HZ);
   localparam int DEF_BLINK_HALF_CYCLES = half_cycles(BLINK_CLK_HZ);

endpackage : clock_div_pkg

// File: rtl/clock_div_channel.sv
// Purpose: one divider channel, a wrap-at-HALF_CYCLES-1 counter driving a toggle flop.
// Latency: first rise on the HALF_CYCLES-th clk edge after reset release, then every HALF_CYCLES edges.
// Backpressure: none; free-running.
module clk_div_channel
   import clock_div_pkg::*;
#(
   parameter int HALF_CYCLES = 1
) (
   input  logic clk,
   input  logic rst,
   output logic out
);

   // A counter of clog2(HALF_CYCLES) bits holds 0..HALF_CYCLES-1; keep at least one bit
   // so the HALF_CYCLES=1 case (counter pinned at 0) still elaborates.
   localparam int CNT_W = (HALF_CYCLES > 1) ? $clog2(HALF_CYCLES) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(HALF_CYCLES - 1);

   // A half-period of zero edges has no meaning; stop elaboration outright.
   if (HALF_CYCLES < 1) begin : g_bad_half_cycles
      $fatal(1, "clk_div_channel: HALF_CYCLES must be >= 1");
   end

   logic [CNT_W-1:0] r_cnt;
   logic             r_out;
   logic             w_wrap;

   // Wrap is explicit at HALF_CYCLES-1 so the counter never relies on 2^N overflow.
   assign w_wrap = (r_cnt == LAST_CNT);

   // Count edges within the half-period; toggle the output on the last one.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
         r_out <= 1'b0;
      end else if (w_wrap) begin
         r_cnt <= '0;
         r_out <= ~r_out;
      end else begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   // Output comes straight from the flop so it cannot glitch.
   assign out = r_out;

endmodule : clk_div_channel

// File: rtl/clock_div.sv
// Purpose: generates fastClk (display scan) and blinkClk (LED/digit blink) from the system clock.
// Latency: each output first rises HALF_CYCLES edges after reset release; outputs are registered.
// Backpressure: none; both channels free-run independently.
module clock_div
   import clock_div_pkg::*;
#(
   parameter int FAST_HALF_CYCLES  = DEF_FAST_HALF_CYCLES,
   parameter int BLINK_HALF_CYCLES = DEF_BLINK_HALF_CYCLES
) (
   input  logic clk,
   input  logic rst,
   output logic fastClk,
   output logic blinkClk
);

   // Scan-rate channel: 500 Hz with the default parameters.
   clk_div_channel #(
      .HALF_CYCLES (FAST_HALF_CYCLES)
   ) u_fast (
      .clk (clk),
      .rst (rst),
      .out (fastClk)
   );

   // Blink-rate channel: 2 Hz with the default parameters.
   clk_div_channel #(
      .HALF_CYCLES (BLINK_HALF_CYCLES)
   ) u_blink (
      .clk (clk),
      .rst (rst),
      .out (blinkClk)
   );

endmodule : clock_div

// File: tb/tb_clock_div.sv
// Purpose: randomized check of clock_div against an edge-counting reference model.
// Latency: outputs sampled on the falling clk edge, mid-cycle resets checked 1 ns after assertion.
// Backpressure: n/a.
module tb_clock_div;

   localparam int FAST_H   = 4;
   localparam int BLINK_H  = 10;
   localparam int FAST1_H  = 1;

   logic clk;
   logic rst;
   logic fastClk, blinkClk;
   logic fastClk1, blinkClk1;

   int n_checks = 0;
   int n_pass   = 0;
   int n_edges  = 0;   // rising edges seen since the last reset release

   clock_div #(
      .FAST_HALF_CYCLES  (FAST_H),
      .BLINK_HALF_CYCLES (BLINK_H)
   ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .fastClk  (fastClk),
      .blinkClk (blinkClk)
   );

   clock_div #(
      .FAST_HALF_CYCLES  (FAST1_H),
      .BLINK_HALF_CYCLES (BLINK_H)
   ) u_dut1 (
      .clk      (clk),
      .rst      (rst),
      .fastClk  (fastClk1),
      .blinkClk (blinkClk1)
   );

   // Falls at 10 ns, first rise at 20 ns, so reset release at 10 ns is clear of any edge.
   initial clk = 1'b1;
   always #10 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp)
         $display("FAIL %s edge=%0d got=%0h exp=%0h", tag, n_edges, got, exp);
      else
         n_pass++;
   endtask

   // Reference: after k edges the output has toggled floor(k/H) times starting from 0.
   function automatic logic model(input int edges, input int half);
      return logic'((edges / half) % 2);
   endfunction

   task automatic check_all();
      chk("fast",   fastClk,   model(n_edges, FAST_H));
      chk("blink",  blinkClk,  model(n_edges, BLINK_H));
      chk("fast1",  fastClk1,  model(n_edges, FAST1_H));
      chk("blink1", blinkClk1, model(n_edges, BLINK_H));
      chk("no_x",   32'($isunknown({fastClk, blinkClk, fastClk1, blinkClk1})), 32'd0);
   endtask

   task automatic run(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk);
         n_edges++;
         @(negedge clk);
         check_all();
      end
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_fast"},   fastClk,   1'b0);
      chk({tag, "_blink"},  blinkClk,  1'b0);
      chk({tag, "_fast1"},  fastClk1,  1'b0);
      chk({tag, "_blink1"}, blinkClk1, 1'b0);
   endtask

   // Called just after a falling-edge sample: assert reset between edges, confirm the
   // outputs drop before the next rising edge, hold across one edge, release mid-cycle.
   task automatic mid_reset();
      #($urandom_range(1, 8));
      rst = 1'b1;
      #1;
      check_zero("async_rst");
      @(posedge clk);
      @(negedge clk);
      check_zero("held_rst");
      #($urandom_range(1, 8));
      rst = 1'b0;
      n_edges = 0;
   endtask

   initial begin
      rst = 1'b1;
      #5;
      check_zero("por");
      #5;
      rst = 1'b0;
      n_edges = 0;

      // First rise at edge 4, fall at 8, joint toggle at edge 20, periods 8 and 20.
      run(100);

      // Reset while both fastClk and blinkClk are high (edges 12..15 of a fresh run).
      mid_reset();
      run(12 + $urandom_range(0, 3));
      chk("pre_rst_fast",  fastClk,  1'b1);
      chk("pre_rst_blink", blinkClk, 1'b1);
      mid_reset();
      run(25);

      // Random reset points.
      repeat (12) begin
         run($urandom_range(5, 90));
         mid_reset();
      end

      // Long free run.
      run(1000);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_clock_div
